// File: rtl/add_serial.sv
// Word-serial NBITS-bit adder with carry-in: one WBITS-wide word per cycle, LSW first.
// Optional modular reduction by q is enabled with `define ADD_SERIAL_MODRED_EN.
module add_serial #(
  parameter int NBITS = 256,
  parameter int WBITS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic             c,
`ifdef ADD_SERIAL_MODRED_EN
  input  logic [NBITS-1:0] q,
`endif
  output logic             busy,
  output logic             done,
  output logic             cout,
  output logic [NBITS-1:0] y
);

  localparam int NUM = NBITS / WBITS;
  localparam int KW  = (NUM > 1) ? $clog2(NUM) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
`ifdef ADD_SERIAL_MODRED_EN
    S_RED,
`endif
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [NBITS-1:0] r_a;
  logic [NBITS-1:0] r_b;
  logic [NBITS-1:0] r_sum;
  logic             r_carry;
  logic [KW-1:0]    r_k;
  logic [NBITS-1:0] r_y;
  logic             r_cout;

  logic             w_last;
  logic [WBITS:0]   w_word;
  logic [NBITS-1:0] w_a_shift;
  logic [NBITS-1:0] w_b_shift;
  logic [NBITS-1:0] w_sum_next;

  assign w_last = (r_k == KW'(NUM - 1));
  assign w_word = {1'b0, r_a[WBITS-1:0]} + {1'b0, r_b[WBITS-1:0]} + {{WBITS{1'b0}}, r_carry};

  // The sum register fills from the top, so after NUM shifts word 0 sits at the bottom.
  if (NUM == 1) begin : g_single
    assign w_a_shift  = '0;
    assign w_b_shift  = '0;
    assign w_sum_next = w_word[WBITS-1:0];
  end else begin : g_multi
    assign w_a_shift  = {{WBITS{1'b0}}, r_a[NBITS-1:WBITS]};
    assign w_b_shift  = {{WBITS{1'b0}}, r_b[NBITS-1:WBITS]};
    assign w_sum_next = {w_word[WBITS-1:0], r_sum[NBITS-1:WBITS]};
  end

`ifdef ADD_SERIAL_MODRED_EN
  logic [NBITS-1:0] r_q;
  logic [NBITS-1:0] r_t;
  logic             r_sumc;
  logic [WBITS:0]   w_diff;
  logic             w_borrow;
  logic [NBITS-1:0] w_sum_rot;
  logic [NBITS-1:0] w_q_shift;
  logic [NBITS-1:0] w_t_next;

  // During RED the sum rotates once per word, so it is back in place after NUM cycles.
  assign w_diff   = {1'b0, r_sum[WBITS-1:0]} - {1'b0, r_q[WBITS-1:0]} - {{WBITS{1'b0}}, r_carry};
  assign w_borrow = w_diff[WBITS];

  if (NUM == 1) begin : g_red_single
    assign w_sum_rot = r_sum;
    assign w_q_shift = '0;
    assign w_t_next  = w_diff[WBITS-1:0];
  end else begin : g_red_multi
    assign w_sum_rot = {r_sum[WBITS-1:0], r_sum[NBITS-1:WBITS]};
    assign w_q_shift = {{WBITS{1'b0}}, r_q[NBITS-1:WBITS]};
    assign w_t_next  = {w_diff[WBITS-1:0], r_t[NBITS-1:WBITS]};
  end
`endif

  // NOTE: the reset is sampled on the clock edge, so it sits inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next_state = S_ADD;
      S_ADD: begin
        busy = 1'b1;
`ifdef ADD_SERIAL_MODRED_EN
        if (w_last) w_next_state = S_RED;
`else
        if (w_last) w_next_state = S_DONE;
`endif
      end
`ifdef ADD_SERIAL_MODRED_EN
      S_RED: begin
        busy = 1'b1;
        if (w_last) w_next_state = S_DONE;
      end
`endif
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_y     <= '0;
      r_cout  <= 1'b0;
`ifdef ADD_SERIAL_MODRED_EN
      r_q     <= '0;
      r_t     <= '0;
      r_sumc  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_a     <= a;
          r_b     <= b;
          r_carry <= c;
          r_k     <= '0;
`ifdef ADD_SERIAL_MODRED_EN
          r_q     <= q;
`endif
        end
        S_ADD: begin
          r_a     <= w_a_shift;
          r_b     <= w_b_shift;
          r_sum   <= w_sum_next;
          r_carry <= w_word[WBITS];
          r_k     <= w_last ? '0 : r_k + 1'b1;
          if (w_last) begin
`ifdef ADD_SERIAL_MODRED_EN
            r_sumc  <= w_word[WBITS];
            r_carry <= 1'b0;
`else
            r_y     <= w_sum_next;
            r_cout  <= w_word[WBITS];
`endif
          end
        end
`ifdef ADD_SERIAL_MODRED_EN
        S_RED: begin
          r_sum   <= w_sum_rot;
          r_q     <= w_q_shift;
          r_t     <= w_t_next;
          r_carry <= w_borrow;
          r_k     <= w_last ? '0 : r_k + 1'b1;
          if (w_last) begin
            // Keep the difference when the sum overflowed or did not go negative.
            r_y    <= (r_sumc || !w_borrow) ? w_t_next : w_sum_rot;
            r_cout <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign y    = r_y;
  assign cout = r_cout;

endmodule

// File: tb/tb_add_serial.sv
// Self-checking bench for add_serial: NBITS=16 with WBITS=4 (NUM=4) and WBITS=16 (NUM=1).
// Expected results come from plain integer arithmetic on the operands.
module tb_add_serial;

  localparam int N    = 16;
  localparam int NUM0 = 4;
`ifdef ADD_SERIAL_MODRED_EN
  localparam int LAT0 = 2 * NUM0 + 1;
  localparam int LAT1 = 3;
`else
  localparam int LAT0 = NUM0 + 1;
  localparam int LAT1 = 2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start, c;
  logic [N-1:0] a, b;
  logic         busy, done, cout;
  logic [N-1:0] y;
  logic         start1, c1;
  logic [N-1:0] a1, b1;
  logic         busy1, done1, cout1;
  logic [N-1:0] y1;
`ifdef ADD_SERIAL_MODRED_EN
  logic [N-1:0] q, q1;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [N:0] last_res;

  always #5 clk = ~clk;

  add_serial #(.NBITS(N), .WBITS(4)) dut0 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c),
`ifdef ADD_SERIAL_MODRED_EN
    .q(q),
`endif
    .busy(busy), .done(done), .cout(cout), .y(y)
  );

  add_serial #(.NBITS(N), .WBITS(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c(c1),
`ifdef ADD_SERIAL_MODRED_EN
    .q(q1),
`endif
    .busy(busy1), .done(done1), .cout(cout1), .y(y1)
  );

  // Reference: {cout, y} = a + b + c, or (a + b + c) mod q with reduction.
  function automatic logic [N:0] model(input logic [N-1:0] aa, input logic [N-1:0] bb, input logic cc);
    int unsigned s;
    s = aa + bb + cc;
`ifdef ADD_SERIAL_MODRED_EN
    return (N+1)'(s % q);
`else
    return (N+1)'(s);
`endif
  endfunction

  // Drives one operation on dut0; the result is observed on the done cycle.
  task automatic do_op(input logic [N-1:0] aa, input logic [N-1:0] bb, input logic cc,
                       input bit repulse, output logic [N:0] got, output int lat,
                       output bit busy_ok, output logic [N:0] held);
    @(negedge clk);
    a = aa; b = bb; c = cc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = N'($urandom); b = N'($urandom); c = 1'($urandom);
    lat = -1; busy_ok = 1'b1; held = {cout, y}; got = 'x;
    for (int n = 1; n <= 40; n++) begin
      if (done) begin
        lat = n; got = {cout, y};
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (repulse && n == 2) begin
        start = 1'b1; a = '1; b = '1;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; start1 = 0; a = 0; b = 0; c = 0; a1 = 0; b1 = 0; c1 = 0;
`ifdef ADD_SERIAL_MODRED_EN
    q = 16'hFFF1; q1 = 16'hFFF1;
`endif
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, cout, y} !== '0) begin
      n_fail++; $display("FAIL reset_dut0: got %b_%b_%b_%h expected all zero", busy, done, cout, y);
    end
    n_checks++;
    if ({busy1, done1, cout1, y1} !== '0) begin
      n_fail++; $display("FAIL reset_dut1: got %b_%b_%b_%h expected all zero", busy1, done1, cout1, y1);
    end
    rst = 1'b0;
    last_res = '0;
  endtask

  task automatic check_op(input string name, input logic [N-1:0] aa, input logic [N-1:0] bb,
                          input logic cc, input bit repulse);
    logic [N:0] got, held, exp;
    int lat; bit bok;
    exp = model(aa, bb, cc);
    do_op(aa, bb, cc, repulse, got, lat, bok, held);
    n_checks++;
    if (lat != LAT0) begin
      n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, LAT0);
    end
    n_checks++;
    if (!bok) begin
      n_fail++; $display("FAIL %s_busy: busy profile wrong (got 0 expected 1)", name);
    end
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL %s_result a=%h b=%h c=%b: got %h expected %h", name, aa, bb, cc, got, exp);
    end
    n_checks++;
    if (held !== last_res) begin
      n_fail++; $display("FAIL %s_hold: got %h expected %h", name, held, last_res);
    end
    last_res = exp;
  endtask

  task automatic test_directed();
`ifdef ADD_SERIAL_MODRED_EN
    q = 16'hFFF1;
    check_op("dir_red", 16'hFFF0, 16'h0005, 1'b0, 1'b0);
    check_op("dir_nored", 16'h0001, 16'h0002, 1'b0, 1'b0);
    check_op("dir_max", 16'hFFF0, 16'hFFF0, 1'b1, 1'b0);
    check_op("dir_zero", 16'h0000, 16'h0000, 1'b0, 1'b0);
`else
    check_op("dir_basic", 16'h1234, 16'h1111, 1'b0, 1'b0);
    check_op("dir_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    check_op("dir_max", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    check_op("dir_zero", 16'h0000, 16'h0000, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_random();
    logic [N-1:0] ra, rb;
    for (int i = 0; i < 20; i++) begin
`ifdef ADD_SERIAL_MODRED_EN
      q  = N'($urandom_range(2, 65535));
      ra = N'($urandom % q);
      rb = N'($urandom % q);
`else
      ra = N'($urandom);
      rb = N'($urandom);
`endif
      check_op("rand", ra, rb, 1'($urandom), 1'b0);
    end
  endtask

  task automatic test_ignore_start();
    bit quiet;
`ifdef ADD_SERIAL_MODRED_EN
    q = 16'hFFF1;
`endif
    check_op("ignore", 16'h0F0F, 16'h00F1, 1'b0, 1'b1);
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (busy || done) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) begin
      n_fail++; $display("FAIL ignore_not_queued: got activity 1 expected 0");
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] ra, rb;
    for (int i = 0; i < 3; i++) begin
`ifdef ADD_SERIAL_MODRED_EN
      ra = N'($urandom % q); rb = N'($urandom % q);
`else
      ra = N'($urandom); rb = N'($urandom);
`endif
      check_op("b2b", ra, rb, 1'($urandom), 1'b0);
    end
  endtask

  task automatic test_abort();
    bit no_done;
`ifdef ADD_SERIAL_MODRED_EN
    q = 16'hFFF1;
`endif
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; c = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, cout, y} !== '0) begin
      n_fail++; $display("FAIL abort_reset: got %b_%b_%b_%h expected all zero", busy, done, cout, y);
    end
    rst = 1'b0;
    no_done = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) no_done = 1'b0;
    end
    n_checks++;
    if (!no_done) begin
      n_fail++; $display("FAIL abort_no_done: got activity 1 expected 0");
    end
    last_res = '0;
    check_op("after_abort", 16'h0001, 16'h0002, 1'b0, 1'b0);
  endtask

  task automatic test_num1();
    logic [N:0] exp;
    int lat;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
`ifdef ADD_SERIAL_MODRED_EN
      q = 16'hFFF1; q1 = q;
      a1 = (i == 0) ? 16'h8000 : N'($urandom % q);
      b1 = (i == 0) ? 16'h8000 : N'($urandom % q);
`else
      a1 = (i == 0) ? 16'h8000 : N'($urandom);
      b1 = (i == 0) ? 16'h8000 : N'($urandom);
`endif
      c1 = (i == 0) ? 1'b0 : 1'($urandom);
      exp = model(a1, b1, c1);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; a1 = N'($urandom); b1 = N'($urandom);
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
        if (done1) begin lat = n; break; end
        @(negedge clk);
      end
      n_checks++;
      if (lat != LAT1) begin
        n_fail++; $display("FAIL num1_latency: got %0d expected %0d", lat, LAT1);
      end
      n_checks++;
      if ({cout1, y1} !== exp) begin
        n_fail++; $display("FAIL num1_result: got %h expected %h", {cout1, y1}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    test_num1();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
